// File: rtl/clock_pkg.sv
// Shared BCD helpers for the clock/calendar counter stages.
// Vectors are sized for the widest supported field (4 digits).
package clock_pkg;
    localparam int BCD_W      = 4;
    localparam int MAX_DIGITS = 4;
    localparam int VEC_W      = BCD_W * MAX_DIGITS;

    function automatic logic [VEC_W-1:0] to_bcd(input int value, input int digits);
        logic [VEC_W-1:0] r;
        int v;
        r = '0;
        v = value;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits) begin
                r[i*BCD_W +: BCD_W] = BCD_W'(v % 10);
                v = v / 10;
            end
        end
        return r;
    endfunction

    function automatic logic bcd_valid(input logic [VEC_W-1:0] vec, input int digits);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits && vec[i*BCD_W +: BCD_W] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic int bcd_to_int(input logic [VEC_W-1:0] vec, input int digits);
        int r;
        int scale;
        r     = 0;
        scale = 1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits) begin
                r     = r + int'(vec[i*BCD_W +: BCD_W]) * scale;
                scale = scale * 10;
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/bcd_digit.sv
// One 0-9 BCD digit register; carry/borrow out are combinational so a
// multi-digit step ripples through all digits within one cycle.
module bcd_digit #(
    parameter logic [3:0] RST_VAL = 4'd0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_inc,
    input  logic       i_dec,
    input  logic       i_ld,
    input  logic [3:0] i_ld_val,
    output logic [3:0] o_d,
    output logic       o_co,
    output logic       o_bo
);
    logic [3:0] d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            d <= RST_VAL;
        end else if (i_ld) begin
            d <= i_ld_val;
        end else if (i_inc) begin
            d <= (d == 4'd9) ? 4'd0 : d + 4'd1;
        end else if (i_dec) begin
            d <= (d == 4'd0) ? 4'd9 : d - 4'd1;
        end
    end

    assign o_d  = d;
    assign o_co = i_inc && (d == 4'd9);
    assign o_bo = i_dec && (d == 4'd0);
endmodule

// File: rtl/bcd_modulo_counter.sv
// Multi-digit BCD up/down counter over [MIN_VAL, MIN_VAL+MODULUS-1] with
// validated parallel load and registered carry/borrow/load-error pulses.
module bcd_modulo_counter
    import clock_pkg::*;
#(
    parameter int DIGITS  = 2,
    parameter int MODULUS = 60,
    parameter int MIN_VAL = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_ena,
    input  logic                  i_up,
    input  logic                  i_down,
    input  logic                  i_wr,
    input  logic [4*DIGITS-1:0]   i_in,
    output logic [4*DIGITS-1:0]   o_q,
    output logic                  o_carry,
    output logic                  o_borrow,
    output logic                  o_wr_err
);
    localparam int W       = BCD_W * DIGITS;
    localparam int MAX_VAL = MIN_VAL + MODULUS - 1;
    localparam logic [W-1:0] MIN_BCD = W'(to_bcd(MIN_VAL, DIGITS));
    localparam logic [W-1:0] MAX_BCD = W'(to_bcd(MAX_VAL, DIGITS));

    if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_bad_digits
        $error("bcd_modulo_counter: DIGITS must be 1..4");
    end
    if (MODULUS < 2 || MIN_VAL < 0 || MAX_VAL >= 10**DIGITS) begin : g_bad_range
        $error("bcd_modulo_counter: MIN_VAL+MODULUS-1 must fit in DIGITS");
    end

    logic [W-1:0]     q;
    logic [W-1:0]     ld_val;
    logic [VEC_W-1:0] in_ext;
    logic             do_wr, do_up, do_dn;
    logic             at_min, at_max;
    logic             above_min, wr_ok, ld;
    logic [DIGITS:0]  inc_chain, dec_chain;
    logic [1:0]       unused_chain;

    assign do_wr = i_ena && i_wr;
    assign do_up = i_ena && !i_wr && i_up;
    assign do_dn = i_ena && !i_wr && !i_up && i_down;

    assign at_min = (q == MIN_BCD);
    assign at_max = (q == MAX_BCD);

    // For valid BCD, numeric order matches plain vector order.
    if (MIN_VAL == 0) begin : g_min_zero
        assign above_min = 1'b1;
    end else begin : g_min_cmp
        assign above_min = (i_in >= MIN_BCD);
    end
    assign in_ext = VEC_W'(i_in);
    assign wr_ok  = bcd_valid(in_ext, DIGITS) && above_min && (i_in <= MAX_BCD);

    // Wraps are done as a load of the opposite bound.
    assign ld = (do_wr && wr_ok) || (do_up && at_max) || (do_dn && at_min);

    always_comb begin
        ld_val = MAX_BCD;
        if (do_wr)      ld_val = i_in;
        else if (do_up) ld_val = MIN_BCD;
    end

    assign inc_chain[0] = do_up && !at_max;
    assign dec_chain[0] = do_dn && !at_min;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit #(
            .RST_VAL(MIN_BCD[k*BCD_W +: BCD_W])
        ) u_digit (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_inc   (inc_chain[k]),
            .i_dec   (dec_chain[k]),
            .i_ld    (ld),
            .i_ld_val(ld_val[k*BCD_W +: BCD_W]),
            .o_d     (q[k*BCD_W +: BCD_W]),
            .o_co    (inc_chain[k+1]),
            .o_bo    (dec_chain[k+1])
        );
    end

    // The top digit's ripple-out is never needed: the bounds catch it first.
    assign unused_chain = {inc_chain[DIGITS], dec_chain[DIGITS]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_carry  <= 1'b0;
            o_borrow <= 1'b0;
            o_wr_err <= 1'b0;
        end else begin
            o_carry  <= do_up && at_max;
            o_borrow <= do_dn && at_min;
            o_wr_err <= do_wr && !wr_ok;
        end
    end

    assign o_q = q;
endmodule

// File: tb/tb_bcd_modulo_counter.sv
// Bench for bcd_modulo_counter: several parameterisations plus a two-stage
// cascade, all checked every cycle against an integer reference model.
module tb_bcd_modulo_counter;
    localparam int N = 5;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [N-1:0] ena, up, dn, wr;
    logic [15:0] din [N];
    logic [N-1:0] cy_o, bo_o, er_o;
    logic [7:0]  q0, q1, q3, q4;
    logic [11:0] q2;

    int m_cnt [N];
    bit m_cy  [N];
    bit m_bo  [N];
    bit m_er  [N];
    int mins  [N] = '{0, 1, 1, 0, 0};
    int maxs  [N] = '{59, 12, 366, 59, 23};
    int digs  [N] = '{2, 2, 3, 2, 2};

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bcd_modulo_counter u_sec (
        .i_clk(clk), .i_rst_n(rst_n), .i_ena(ena[0]), .i_up(up[0]), .i_down(dn[0]),
        .i_wr(wr[0]), .i_in(din[0][7:0]), .o_q(q0), .o_carry(cy_o[0]),
        .o_borrow(bo_o[0]), .o_wr_err(er_o[0])
    );
    bcd_modulo_counter #(.DIGITS(2), .MODULUS(12), .MIN_VAL(1)) u_hr12 (
        .i_clk(clk), .i_rst_n(rst_n), .i_ena(ena[1]), .i_up(up[1]), .i_down(dn[1]),
        .i_wr(wr[1]), .i_in(din[1][7:0]), .o_q(q1), .o_carry(cy_o[1]),
        .o_borrow(bo_o[1]), .o_wr_err(er_o[1])
    );
    bcd_modulo_counter #(.DIGITS(3), .MODULUS(366), .MIN_VAL(1)) u_doy (
        .i_clk(clk), .i_rst_n(rst_n), .i_ena(ena[2]), .i_up(up[2]), .i_down(dn[2]),
        .i_wr(wr[2]), .i_in(din[2][11:0]), .o_q(q2), .o_carry(cy_o[2]),
        .o_borrow(bo_o[2]), .o_wr_err(er_o[2])
    );
    bcd_modulo_counter #(.DIGITS(2), .MODULUS(60), .MIN_VAL(0)) u_cas_lo (
        .i_clk(clk), .i_rst_n(rst_n), .i_ena(ena[3]), .i_up(up[3]), .i_down(dn[3]),
        .i_wr(wr[3]), .i_in(din[3][7:0]), .o_q(q3), .o_carry(cy_o[3]),
        .o_borrow(bo_o[3]), .o_wr_err(er_o[3])
    );
    // Upper stage is enabled by the lower stage's carry; wr[4] also enables it for preset.
    bcd_modulo_counter #(.DIGITS(2), .MODULUS(24), .MIN_VAL(0)) u_cas_hi (
        .i_clk(clk), .i_rst_n(rst_n), .i_ena(cy_o[3] | wr[4]), .i_up(up[4]), .i_down(dn[4]),
        .i_wr(wr[4]), .i_in(din[4][7:0]), .o_q(q4), .o_carry(cy_o[4]),
        .o_borrow(bo_o[4]), .o_wr_err(er_o[4])
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] tb_bcd(input int v);
        logic [15:0] r;
        int x;
        r = '0;
        x = v;
        for (int k = 0; k < 4; k++) begin
            r[k*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int get_q(input int i);
        case (i)
            0:       return int'(q0);
            1:       return int'(q1);
            2:       return int'(q2);
            3:       return int'(q3);
            default: return int'(q4);
        endcase
    endfunction

    function automatic void mstep(input int i, input bit e, input bit u, input bit d,
                                  input bit w, input logic [15:0] v);
        bit ok;
        int val;
        int scale;
        m_cy[i] = 0;
        m_bo[i] = 0;
        m_er[i] = 0;
        if (!e) return;
        if (w) begin
            ok    = 1;
            val   = 0;
            scale = 1;
            for (int k = 0; k < digs[i]; k++) begin
                if (v[k*4 +: 4] > 4'd9) ok = 0;
                val   = val + int'(v[k*4 +: 4]) * scale;
                scale = scale * 10;
            end
            if (ok && val >= mins[i] && val <= maxs[i]) m_cnt[i] = val;
            else m_er[i] = 1;
        end else if (u) begin
            if (m_cnt[i] == maxs[i]) begin m_cnt[i] = mins[i]; m_cy[i] = 1; end
            else m_cnt[i] = m_cnt[i] + 1;
        end else if (d) begin
            if (m_cnt[i] == mins[i]) begin m_cnt[i] = maxs[i]; m_bo[i] = 1; end
            else m_cnt[i] = m_cnt[i] - 1;
        end
    endfunction

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            check($sformatf("q%0d", i), get_q(i), int'(tb_bcd(m_cnt[i])));
            check($sformatf("carry%0d", i), int'(cy_o[i]), int'(m_cy[i]));
            check($sformatf("borrow%0d", i), int'(bo_o[i]), int'(m_bo[i]));
            check($sformatf("wr_err%0d", i), int'(er_o[i]), int'(m_er[i]));
        end
    endtask

    task automatic reset_models();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = mins[i];
            m_cy[i]  = 0;
            m_bo[i]  = 0;
            m_er[i]  = 0;
        end
    endtask

    task automatic idle();
        ena = 5'b01111;
        up  = 5'b10000;
        dn  = '0;
        wr  = '0;
        for (int i = 0; i < N; i++) din[i] = '0;
    endtask

    task automatic tick();
        bit prev_lo_cy;
        @(posedge clk);
        #1;
        prev_lo_cy = m_cy[3];
        for (int i = 0; i < N; i++) begin
            if (i == 4) mstep(i, prev_lo_cy | wr[4], up[i], dn[i], wr[i], din[i]);
            else        mstep(i, ena[i], up[i], dn[i], wr[i], din[i]);
        end
        check_all();
    endtask

    initial begin
        idle();
        reset_models();
        #12;
        check_all();
        rst_n = 1'b1;

        // Full 0..59 sweep on the default stage.
        up[0] = 1'b1;
        repeat (60) tick();
        check("sec_wrap_q", int'(q0), 'h00);
        check("sec_wrap_carry", int'(cy_o[0]), 1);
        up[0] = 1'b0;

        // 12-hour field with non-zero minimum.
        dn[1] = 1'b1; tick();
        check("hr12_borrow_q", int'(q1), 'h12);
        dn[1] = 1'b0; up[1] = 1'b1; tick();
        check("hr12_carry_q", int'(q1), 'h01);
        up[1] = 1'b0; wr[1] = 1'b1; din[1] = 16'h0009; tick();
        wr[1] = 1'b0; up[1] = 1'b1; tick();
        check("hr12_ripple_q", int'(q1), 'h10);
        up[1] = 1'b0;

        // Loads on the default stage.
        wr[0] = 1'b1; din[0] = 16'h0045; tick();
        din[0] = 16'h0060; tick();
        check("ld_range_err", int'(er_o[0]), 1);
        wr[0] = 1'b0; tick();
        check("ld_err_clear", int'(er_o[0]), 0);
        wr[0] = 1'b1; din[0] = 16'h003A; tick();
        up[0] = 1'b1; din[0] = 16'h0010; tick();
        check("ld_over_up_q", int'(q0), 'h10);
        wr[0] = 1'b0; up[0] = 1'b0;

        // Up beats down at the top bound; disabled stage holds.
        wr[0] = 1'b1; din[0] = 16'h0059; tick();
        wr[0] = 1'b0; up[0] = 1'b1; dn[0] = 1'b1; tick();
        dn[0] = 1'b0; ena[0] = 1'b0;
        repeat (5) tick();
        ena[0] = 1'b1; up[0] = 1'b0;

        // Asynchronous reset landing mid-cycle while stepping.
        wr[0] = 1'b1; din[0] = 16'h0035; tick();
        wr[0] = 1'b0; up[0] = 1'b1;
        tick(); tick();
        check("pre_reset_q", int'(q0), 'h37);
        #3;
        rst_n = 1'b0;
        reset_models();
        #1;
        check("async_reset_q", int'(q0), 'h00);
        check_all();
        #2;
        rst_n = 1'b1;
        tick();
        check("resume_q", int'(q0), 'h01);
        up[0] = 1'b0;

        // Cascade 23:59 -> 00:00.
        wr[3] = 1'b1; din[3] = 16'h0059;
        wr[4] = 1'b1; din[4] = 16'h0023; tick();
        wr[3] = 1'b0; wr[4] = 1'b0;
        up[3] = 1'b1; tick();
        check("cas_lo_wrap", int'(q3), 'h00);
        check("cas_hi_wait", int'(q4), 'h23);
        up[3] = 1'b0; tick();
        check("cas_hi_wrap", int'(q4), 'h00);
        check("cas_hi_carry", int'(cy_o[4]), 1);
        tick();

        // Randomised traffic on all stages.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 4; i++) begin
                ena[i] = ($urandom_range(0, 7) != 0);
                up[i]  = $urandom_range(0, 1) == 1;
                dn[i]  = $urandom_range(0, 1) == 1;
                wr[i]  = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 1) == 1)
                    din[i] = tb_bcd($urandom_range(mins[i], maxs[i]));
                else
                    din[i] = 16'($urandom);
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bcd_modulo_counter.md
# bcd_modulo_counter

Parametrised multi-digit BCD up/down counter with arbitrary modulus, non-zero minimum value, validated parallel load and registered wrap pulses. Generalises the fixed two-digit 0–59 counter so one block serves seconds/minutes (0–59), 24-hour (0–23), 12-hour (1–12) and day-of-month style fields. Stages cascade through `o_carry`/`o_borrow` into the next stage's `i_ena` in the clock/calendar datapath.

## Interface
Parameters:
- `DIGITS`, 2: number of BCD digits, 1..4.
- `MODULUS`, 60: number of distinct states, 2..10^DIGITS.
- `MIN_VAL`, 0: lowest count (binary integer). `MAX_VAL = MIN_VAL + MODULUS - 1` must be < 10^DIGITS; elaboration error otherwise.

Ports:
- `i_clk` in 1: single clock, all state on rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_ena` in 1: qualifies every action; no state change while low.
- `i_up` in 1: count up one step.
- `i_down` in 1: count down one step.
- `i_wr` in 1: parallel load request.
- `i_in` in 4*DIGITS: BCD load value, digit 0 in [3:0].
- `o_q` out 4*DIGITS: current count, BCD.
- `o_carry` out 1: one-cycle pulse, count wrapped MAX_VAL→MIN_VAL.
- `o_borrow` out 1: one-cycle pulse, count wrapped MIN_VAL→MAX_VAL.
- `o_wr_err` out 1: one-cycle pulse, load rejected.

## Operation
- Reset (`i_rst_n`=0, any time, asynchronous): `o_q` = BCD(MIN_VAL), `o_carry`=`o_borrow`=`o_wr_err`=0. Reset mid-count discards the in-flight step.
- Per edge with `i_ena`=1, priority `i_wr` > `i_up` > `i_down`; exactly one action per cycle.
- Load: accepted iff every digit ≤ 9 and MIN_VAL ≤ value ≤ MAX_VAL. Accepted → `o_q` = `i_in`. Rejected → `o_q` unchanged, `o_wr_err`=1 next cycle. Load never asserts carry/borrow.
- Up: `o_q`==MAX_VAL → `o_q`=MIN_VAL, `o_carry`=1; else BCD increment (digit 9→0 ripples +1 into next digit within the same cycle).
- Down: `o_q`==MIN_VAL → `o_q`=MAX_VAL, `o_borrow`=1; else BCD decrement (digit 0→9 ripples borrow).
- `i_up` and `i_down` both high, no `i_wr`: up wins.
- `i_ena`=0 or no request: `o_q` holds; all pulses 0.
- Pulse outputs are 0 in any cycle not directly following a qualifying wrap/reject; never held for two cycles by one event.
- Count value can never leave [MIN_VAL, MAX_VAL] and no digit ever exceeds 9.

## Timing
- `o_q`, `o_carry`, `o_borrow`, `o_wr_err` are all registered; update on the same edge that samples the request (latency 1 cycle, request-to-output).
- `o_carry`/`o_borrow` are high in the cycle in which `o_q` first shows the wrapped value; downstream stage using `o_carry` as `i_ena` (with `i_up`=1) steps one cycle after this stage wraps. N cascaded stages ⇒ N-1 cycles skew on full rollover.
- No combinational path from any input to any output.
- Throughput: one step per enabled cycle; back-to-back steps and alternating up/down are legal.

## Structure
- Shared package `clock_pkg`: `BCD_W`=4, function `to_bcd(int, digits)`, function `bcd_valid(vec)`, function `bcd_to_int(vec)`; used for MIN/MAX constants and the load check.
- Sub-module `bcd_digit`: one 0–9 digit register with inc/dec/load inputs and combinational digit carry-out/borrow-out; instantiated DIGITS times via generate. Top level owns range compare, wrap forcing (load of MIN/MAX constant), priority, and pulse registers.

## Test plan
- Default params, reset, then 60 enabled ups from 00 → `o_q` steps 00..59 then 00; `o_carry`=1 only in the cycle showing 00, 0 elsewhere.
- DIGITS=2, MODULUS=12, MIN_VAL=1: reset → 01; down once → 12 with `o_borrow`=1; up from 12 → 01 with `o_carry`=1; 09 up → 10.
- Default params, loads: 0x45 → `o_q`=45; 0x60 → rejected, `o_q` stays 45, `o_wr_err`=1 one cycle; 0x3A → rejected; `i_wr`+`i_up` with 0x10 → 10, no carry.
- Simultaneous `i_up`=`i_down`=1 at 59 → 00 with `o_carry`; `i_ena`=0 with `i_up`=1 for 5 cycles → `o_q` unchanged, no pulses.
- Assert `i_rst_n`=0 asynchronously mid-cycle at count 37 while stepping → `o_q`=00 immediately, pulses 0; release → counting resumes from 00 on the next enabled edge.
- Cascade two instances (MODULUS 60, then 24, second `i_ena`=first `o_carry`, `i_up`=1): from 23:59 one step → 00:00 with second stage's `o_carry` pulsing one cycle after the first.
